// File: rtl/mult_regs_pkg.sv
// Shared definitions for the multiplier control register block:
// register addresses, bit positions, mode encodings and sequencer states.
package mult_regs_pkg;

  // Byte addresses of the register map
  localparam int unsigned ADDR_CTRL     = 32'h0;
  localparam int unsigned ADDR_OPERANDS = 32'h4;
  localparam int unsigned ADDR_RESULT   = 32'h8;
  localparam int unsigned ADDR_STATUS   = 32'hC;

  // CTRL bit positions
  localparam int CTRL_RUN      = 0;
  localparam int CTRL_START    = 1;
  localparam int CTRL_MODE_LSB = 2;

  // STATUS bit positions
  localparam int STAT_DONE    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_TIMEOUT = 3;

  // Multiplier mode (cm) encodings
  typedef enum logic [1:0] {
    MODE_S8   = 2'b00,
    MODE_P8   = 2'b01,
    MODE_16   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_START = 2'b10,
    ST_WAIT  = 2'b11
  } state_e;

endpackage

// File: rtl/mult_seq_fsm.sv
// Operation sequencer: flushes the multiplier with a one-cycle reset,
// issues a one-cycle enable, then waits for completion or timeout.
// Holds the shadow copies of operands and mode seen by the multiplier.
module mult_seq_fsm
  import mult_regs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        run_i,          // RUN as it stands after this edge
  input  logic        start_i,        // validated start command
  input  logic [1:0]  mode_i,
  input  logic [31:0] operands_i,
  input  logic        data_valid_i,
  output logic        busy_o,
  output logic        clear_o,
  output logic        mul_enable_o,
  output logic        done_set_o,
  output logic        timeout_set_o,
  output logic [15:0] multiplicand_o,
  output logic [15:0] multiplier_o,
  output logic [1:0]  cm_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             wait_last;

  assign wait_last = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    // NOTE: non-blocking (<=) in every clocked block, so all flops sample
    // pre-edge values; same-cycle reads therefore see pre-update state.
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; dropping RUN aborts from any state
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    if (!run_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_i) state_d = ST_CLEAR;
        ST_CLEAR: state_d = ST_START;
        ST_START: state_d = ST_WAIT;
        ST_WAIT:  if (data_valid_i || wait_last) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the current state; completion wins over timeout
  always_comb begin
    busy_o        = (state_q != ST_IDLE);
    clear_o       = (state_q == ST_CLEAR);
    mul_enable_o  = (state_q == ST_START);
    done_set_o    = run_i && (state_q == ST_WAIT) && data_valid_i;
    timeout_set_o = run_i && (state_q == ST_WAIT) && !data_valid_i && wait_last;
  end

  // WAIT cycle counter, zero on every entry to WAIT
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                                      cnt_q <= '0;
    else if (state_q == ST_WAIT && state_d == ST_WAIT)  cnt_q <= cnt_q + 1'b1;
    else                                                cnt_q <= '0;
  end

  // Shadows capture operands and mode only when an operation is launched
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      multiplicand_o <= '0;
      multiplier_o   <= '0;
      cm_o           <= '0;
    end else if (state_q == ST_IDLE && state_d == ST_CLEAR) begin
      multiplicand_o <= operands_i[31:16];
      multiplier_o   <= operands_i[15:0];
      cm_o           <= mode_i;
    end
  end

endmodule

// File: rtl/mult_ctrl_regs.sv
// Register-mapped front end for configurable_multiplication: CTRL,
// OPERANDS, RESULT and STATUS registers, sticky W1C flags, read port.
module mult_ctrl_regs
  import mult_regs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 4
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [31:0]       rd_data_o,
  output logic              rd_valid_o,
  output logic [15:0]       multiplicand_o,
  output logic [15:0]       multiplier_o,
  output logic              mul_reset_no,
  output logic              mul_enable_o,
  output logic [1:0]        cm_o,
  input  logic [31:0]       product_i,
  input  logic              data_valid_i
);

  logic        run_q;
  logic [1:0]  mode_q;
  logic [31:0] operands_q, result_q;
  logic        done_q, err_q, timeout_q;

  logic        wr_ctrl, wr_operands, wr_status;
  logic        run_d, start_req, start_ok, err_set;
  logic [1:0]  mode_wr;
  logic        busy, clear, done_set, timeout_set;
  logic [31:0] rd_mux;

  assign wr_ctrl     = wr_en_i && (wr_addr_i == ADDR_W'(ADDR_CTRL));
  assign wr_operands = wr_en_i && (wr_addr_i == ADDR_W'(ADDR_OPERANDS));
  assign wr_status   = wr_en_i && (wr_addr_i == ADDR_W'(ADDR_STATUS));

  // A start is judged against the RUN/MODE carried by the same CTRL write
  assign mode_wr   = wr_data_i[CTRL_MODE_LSB +: 2];
  assign run_d     = wr_ctrl ? wr_data_i[CTRL_RUN] : run_q;
  assign start_req = wr_ctrl && wr_data_i[CTRL_START];
  assign start_ok  = start_req && !busy && run_d && (mode_wr != MODE_RSVD);
  assign err_set   = start_req && !start_ok;

  assign mul_reset_no = run_q && !clear;

  mult_seq_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_seq (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .run_i          (run_d),
    .start_i        (start_ok),
    .mode_i         (mode_wr),
    .operands_i     (operands_q),
    .data_valid_i   (data_valid_i),
    .busy_o         (busy),
    .clear_o        (clear),
    .mul_enable_o   (mul_enable_o),
    .done_set_o     (done_set),
    .timeout_set_o  (timeout_set),
    .multiplicand_o (multiplicand_o),
    .multiplier_o   (multiplier_o),
    .cm_o           (cm_o)
  );

  // CTRL and OPERANDS registers; writes while busy never reach the shadows
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      run_q      <= 1'b0;
      mode_q     <= '0;
      operands_q <= '0;
    end else begin
      if (wr_ctrl) begin
        run_q  <= wr_data_i[CTRL_RUN];
        mode_q <= mode_wr;
      end
      if (wr_operands) operands_q <= wr_data_i;
    end
  end

  // RESULT latch and sticky STATUS flags; a set beats a same-cycle W1C
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      result_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (done_set) result_q <= product_i;

      if (done_set)                                          done_q <= 1'b1;
      else if (start_ok || (wr_status && wr_data_i[STAT_DONE])) done_q <= 1'b0;

      if (err_set)                                   err_q <= 1'b1;
      else if (wr_status && wr_data_i[STAT_ERR])     err_q <= 1'b0;

      if (timeout_set)                                            timeout_q <= 1'b1;
      else if (start_ok || (wr_status && wr_data_i[STAT_TIMEOUT])) timeout_q <= 1'b0;
    end
  end

  // Read mux; unmapped addresses return zero, START always reads zero
  always_comb begin
    rd_mux = '0;
    if (rd_addr_i == ADDR_W'(ADDR_CTRL)) begin
      rd_mux[CTRL_RUN]               = run_q;
      rd_mux[CTRL_MODE_LSB +: 2]     = mode_q;
    end else if (rd_addr_i == ADDR_W'(ADDR_OPERANDS)) begin
      rd_mux = operands_q;
    end else if (rd_addr_i == ADDR_W'(ADDR_RESULT)) begin
      rd_mux = result_q;
    end else if (rd_addr_i == ADDR_W'(ADDR_STATUS)) begin
      rd_mux[STAT_DONE]    = done_q;
      rd_mux[STAT_BUSY]    = busy;
      rd_mux[STAT_ERR]     = err_q;
      rd_mux[STAT_TIMEOUT] = timeout_q;
    end
  end

  // Registered read response, one cycle after the strobe
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_en_i;
      rd_data_o  <= rd_en_i ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_mult_ctrl_regs.sv
// Self-checking bench for mult_ctrl_regs: register-access vector table,
// directed sequences for the multi-cycle corners, then randomized
// operations scored against a transaction-level model of the register file.
module tb_mult_ctrl_regs;
  import mult_regs_pkg::*;

  localparam int TO = 8;
  localparam logic [3:0] A_CTRL   = 4'(ADDR_CTRL);
  localparam logic [3:0] A_OPER   = 4'(ADDR_OPERANDS);
  localparam logic [3:0] A_RESULT = 4'(ADDR_RESULT);
  localparam logic [3:0] A_STATUS = 4'(ADDR_STATUS);

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        wr_en_i = 1'b0, rd_en_i = 1'b0, data_valid_i = 1'b0;
  logic [3:0]  wr_addr_i = '0, rd_addr_i = '0;
  logic [31:0] wr_data_i = '0, product_i = '0;
  logic [31:0] rd_data_o;
  logic        rd_valid_o, mul_reset_no, mul_enable_o;
  logic [15:0] multiplicand_o, multiplier_o;
  logic [1:0]  cm_o;

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;

  mult_ctrl_regs #(.TIMEOUT_CYCLES(TO), .ADDR_W(4)) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .wr_en_i        (wr_en_i),
    .wr_addr_i      (wr_addr_i),
    .wr_data_i      (wr_data_i),
    .rd_en_i        (rd_en_i),
    .rd_addr_i      (rd_addr_i),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .multiplicand_o (multiplicand_o),
    .multiplier_o   (multiplier_o),
    .mul_reset_no   (mul_reset_no),
    .mul_enable_o   (mul_enable_o),
    .cm_o           (cm_o),
    .product_i      (product_i),
    .data_valid_i   (data_valid_i)
  );

  always #5 clk_i = ~clk_i;

  // Count enable pulses, sampled mid-cycle
  always @(negedge clk_i) if (mul_enable_o) en_count++;

  typedef struct {
    logic        wr;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_rstn;
  } vec_t;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    tick();
    wr_en_i = 1'b0; wr_data_i = '0;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    rd_en_i = 1'b1; rd_addr_i = a;
    tick();
    rd_en_i = 1'b0;
    check({name, " valid"}, 32'(rd_valid_o), 32'h1);
    check(name, rd_data_o, exp);
  endtask

  // Called right after the CTRL write edge: CLEAR, then START, then WAIT
  task automatic start_seq(input string tag);
    check({tag, " clear rst_n"}, 32'(mul_reset_no), 32'h0);
    check({tag, " clear en"}, 32'(mul_enable_o), 32'h0);
    tick();
    check({tag, " start en"}, 32'(mul_enable_o), 32'h1);
    check({tag, " start rst_n"}, 32'(mul_reset_no), 32'h1);
    tick();
    check({tag, " wait en"}, 32'(mul_enable_o), 32'h0);
  endtask

  // Multiplier responds after k WAIT cycles with product p
  task automatic finish_ok(input int k, input logic [31:0] p);
    repeat (k) tick();
    data_valid_i = 1'b1; product_i = p;
    tick();
    data_valid_i = 1'b0; product_i = $urandom;
  endtask

  // Stand-in for the multiplier: signed products per mode
  function automatic logic [31:0] mul_model(input logic [1:0] mode, input logic [31:0] ops);
    int a16, b16, ah, bh, al, bl;
    a16 = $signed(ops[31:16]); b16 = $signed(ops[15:0]);
    ah  = $signed(ops[31:24]); bh  = $signed(ops[15:8]);
    al  = $signed(ops[23:16]); bl  = $signed(ops[7:0]);
    case (mode)
      MODE_16: return 32'(a16 * b16);
      MODE_P8: return {16'(ah * bh), 16'(al * bl)};
      MODE_S8: return 32'(al * bl);
      default: return 32'h0;
    endcase
  endfunction

  vec_t        vecs [10];
  int          e0, k;
  logic [31:0] p, ops, mask;
  logic [1:0]  md;
  logic        rn, m_done, m_err, m_to, m_run;
  logic [1:0]  m_mode;
  logic [31:0] m_result;

  initial begin
    vecs[0] = '{1'b1, A_CTRL,   32'h0000_000D, A_CTRL,   32'h0000_000D, 1'b1};
    vecs[1] = '{1'b1, A_CTRL,   32'hFFFF_FFF9, A_CTRL,   32'h0000_0009, 1'b1};
    vecs[2] = '{1'b1, A_OPER,   32'h1234_5678, A_OPER,   32'h1234_5678, 1'b1};
    vecs[3] = '{1'b1, 4'h6,     32'hDEAD_BEEF, 4'h6,     32'h0,         1'b1};
    vecs[4] = '{1'b1, A_RESULT, 32'hFFFF_FFFF, A_RESULT, 32'h0,         1'b1};
    vecs[5] = '{1'b1, A_STATUS, 32'h0000_000F, A_STATUS, 32'h0,         1'b1};
    vecs[6] = '{1'b0, 4'h0,     32'h0,         A_OPER,   32'h1234_5678, 1'b1};
    vecs[7] = '{1'b1, 4'h3,     32'h0000_00AA, 4'h3,     32'h0,         1'b1};
    vecs[8] = '{1'b1, A_CTRL,   32'h0,         A_CTRL,   32'h0,         1'b0};
    vecs[9] = '{1'b1, 4'h1,     32'h0000_FFFF, A_OPER,   32'h1234_5678, 1'b0};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst rd_data", rd_data_o, 32'h0);
    check("rst rd_valid", 32'(rd_valid_o), 32'h0);
    check("rst enable", 32'(mul_enable_o), 32'h0);
    check("rst mul_rst_n", 32'(mul_reset_no), 32'h0);
    check("rst cm", 32'(cm_o), 32'h0);
    check("rst mcand", 32'(multiplicand_o), 32'h0);
    check("rst mplier", 32'(multiplier_o), 32'h0);
    reset_ni = 1'b1;
    tick();

    // Register access table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].waddr, vecs[i].wdata);
      read_check($sformatf("vec%0d rd", i), vecs[i].raddr, vecs[i].exp_rd);
      check($sformatf("vec%0d mul_rst_n", i), 32'(mul_reset_no), 32'(vecs[i].exp_rstn));
    end
    tick();
    check("idle rd_valid", 32'(rd_valid_o), 32'h0);
    check("idle rd_data", rd_data_o, 32'h0);

    // 16-bit operation
    bus_write(A_OPER, 32'hF2BA_1BF7);
    e0 = en_count;
    bus_write(A_CTRL, 32'h0B);
    start_seq("16b");
    check("16b cm", 32'(cm_o), 32'(MODE_16));
    check("16b mcand", 32'(multiplicand_o), 32'hF2BA);
    check("16b mplier", 32'(multiplier_o), 32'h1BF7);
    finish_ok(3, mul_model(MODE_16, 32'hF2BA_1BF7));
    check("16b pulses", en_count - e0, 32'h1);
    read_check("16b RESULT", A_RESULT, 32'hFE8C_CF76);
    read_check("16b STATUS", A_STATUS, 32'h1);

    // Parallel 8-bit operation
    e0 = en_count;
    bus_write(A_CTRL, 32'h07);
    start_seq("p8");
    check("p8 cm", 32'(cm_o), 32'(MODE_P8));
    p = mul_model(MODE_P8, 32'hF2BA_1BF7);
    finish_ok(1, p);
    check("p8 pulses", en_count - e0, 32'h1);
    read_check("p8 RESULT", A_RESULT, p);
    read_check("p8 STATUS", A_STATUS, 32'h1);
    bus_write(A_STATUS, 32'h1);
    read_check("p8 W1C", A_STATUS, 32'h0);

    // Reserved mode: no sequence, ERR only
    e0 = en_count;
    bus_write(A_CTRL, 32'h0F);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rsvd no clear %0d", i), 32'(mul_reset_no), 32'h1);
      tick();
    end
    check("rsvd pulses", en_count - e0, 32'h0);
    read_check("rsvd STATUS", A_STATUS, 32'h4);
    bus_write(A_STATUS, 32'h4);
    read_check("err W1C", A_STATUS, 32'h0);

    // START while busy: ERR set, in-flight op and shadows untouched
    bus_write(A_OPER, 32'h0003_0005);
    bus_write(A_CTRL, 32'h0B);
    tick(); tick();
    bus_write(A_OPER, 32'h1111_2222);
    bus_write(A_CTRL, 32'h03);
    check("busy cm", 32'(cm_o), 32'(MODE_16));
    check("busy mcand", 32'(multiplicand_o), 32'h3);
    check("busy mplier", 32'(multiplier_o), 32'h5);
    finish_ok(0, mul_model(MODE_16, 32'h0003_0005));
    read_check("busy RESULT", A_RESULT, 32'd15);
    read_check("busy STATUS", A_STATUS, 32'h5);
    read_check("busy CTRL", A_CTRL, 32'h1);
    read_check("busy OPER", A_OPER, 32'h1111_2222);

    // Timeout: BUSY through TO WAIT cycles, then TIMEOUT only
    bus_write(A_STATUS, 32'hF);
    bus_write(A_CTRL, 32'h0B);
    tick(); tick();
    for (int i = 0; i < TO; i++)
      read_check($sformatf("to busy %0d", i), A_STATUS, 32'h2);
    read_check("to STATUS", A_STATUS, 32'h8);
    read_check("to RESULT", A_RESULT, 32'd15);

    // Abort by clearing RUN during WAIT
    bus_write(A_STATUS, 32'hF);
    bus_write(A_CTRL, 32'h0B);
    tick(); tick(); tick();
    bus_write(A_CTRL, 32'h00);
    check("abort mul_rst_n", 32'(mul_reset_no), 32'h0);
    check("abort en", 32'(mul_enable_o), 32'h0);
    data_valid_i = 1'b1; product_i = 32'hA5A5_A5A5;
    read_check("abort STATUS", A_STATUS, 32'h0);
    data_valid_i = 1'b0;
    read_check("abort DONE", A_STATUS, 32'h0);
    read_check("abort RESULT", A_RESULT, 32'd15);

    // Collision: completion, W1C DONE and STATUS read in one cycle
    bus_write(A_CTRL, 32'h0B);
    tick(); tick();
    data_valid_i = 1'b1; product_i = 32'h1234_0000;
    wr_en_i = 1'b1; wr_addr_i = A_STATUS; wr_data_i = 32'h1;
    rd_en_i = 1'b1; rd_addr_i = A_STATUS;
    tick();
    data_valid_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0;
    check("coll pre-update", rd_data_o, 32'h2);
    read_check("coll DONE wins", A_STATUS, 32'h1);
    read_check("coll RESULT", A_RESULT, 32'h1234_0000);

    // Asynchronous reset mid-WAIT
    bus_write(A_CTRL, 32'h0B);
    tick(); tick(); tick();
    rd_en_i = 1'b1; rd_addr_i = A_OPER;
    tick();
    rd_en_i = 1'b0;
    check("pre-rst rd_valid", 32'(rd_valid_o), 32'h1);
    #2 reset_ni = 1'b0;
    #1;
    check("arst rd_valid", 32'(rd_valid_o), 32'h0);
    check("arst rd_data", rd_data_o, 32'h0);
    check("arst enable", 32'(mul_enable_o), 32'h0);
    check("arst mul_rst_n", 32'(mul_reset_no), 32'h0);
    check("arst cm", 32'(cm_o), 32'h0);
    check("arst mcand", 32'(multiplicand_o), 32'h0);
    check("arst mplier", 32'(multiplier_o), 32'h0);
    #1 reset_ni = 1'b1;
    tick();
    read_check("arst STATUS", A_STATUS, 32'h0);
    read_check("arst RESULT", A_RESULT, 32'h0);
    read_check("arst CTRL", A_CTRL, 32'h0);
    read_check("arst OPER", A_OPER, 32'h0);

    // Randomized operations against the register-file model
    m_done = 0; m_err = 0; m_to = 0; m_result = '0; m_run = 0; m_mode = '0;
    for (int it = 0; it < 40; it++) begin
      mask = 32'($urandom_range(0, 15));
      bus_write(A_STATUS, mask);
      if (mask[0]) m_done = 1'b0;
      if (mask[2]) m_err  = 1'b0;
      if (mask[3]) m_to   = 1'b0;

      ops = $urandom;
      md  = 2'($urandom_range(0, 3));
      rn  = ($urandom_range(0, 4) != 0);
      bus_write(A_OPER, ops);
      e0 = en_count;
      bus_write(A_CTRL, {28'h0, md, 1'b1, rn});
      m_run = rn; m_mode = md;

      if (!rn || md == 2'b11) begin
        m_err = 1'b1;
        tick(); tick();
        check($sformatf("r%0d no pulse", it), en_count - e0, 32'h0);
      end else begin
        m_done = 1'b0; m_to = 1'b0;
        start_seq($sformatf("r%0d", it));
        check($sformatf("r%0d cm", it), 32'(cm_o), 32'(md));
        check($sformatf("r%0d mcand", it), 32'(multiplicand_o), 32'(ops[31:16]));
        check($sformatf("r%0d mplier", it), 32'(multiplier_o), 32'(ops[15:0]));
        if ($urandom_range(0, 3) == 0) begin
          repeat (TO) tick();
          m_to = 1'b1;
        end else begin
          k = $urandom_range(0, TO - 2);
          p = mul_model(md, ops);
          finish_ok(k, p);
          m_result = p; m_done = 1'b1;
        end
        check($sformatf("r%0d pulses", it), en_count - e0, 32'h1);
      end
      read_check($sformatf("r%0d STATUS", it), A_STATUS, {28'h0, m_to, m_err, 1'b0, m_done});
      read_check($sformatf("r%0d RESULT", it), A_RESULT, m_result);
      read_check($sformatf("r%0d CTRL", it), A_CTRL, {28'h0, m_mode, 1'b0, m_run});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
